// File: rtl/io_clamp_pkg.sv
// Shared types and constants for the IO-ring clamp sequencer.
//   state_e      : sequencer FSM state encoding (2 bits, visible on state_o).
//   MAX_SEG      : largest supported number of IO supply segments.
//   thermo_bit() : one bit of the clamp thermometer code for a given count.
package io_clamp_pkg;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_CLAMPED = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int MAX_SEG = 16;

  // Bit 'pos' of a thermometer code holding 'cnt' ones from bit 0.
  function automatic logic thermo_bit(input logic [4:0] pos, input logic [4:0] cnt);
    return (pos < cnt);
  endfunction

endpackage

// File: rtl/io_clamp_step_timer.sv
// Settle-interval down-counter for the clamp sequencer.
//   clk, rst_n : always-on clock, asynchronous active-low reset (count -> 0).
//   load       : load load_val this cycle (takes priority over counting).
//   load_val   : value to load.
//   enable     : allow a nonzero count to decrement by one.
//   zero       : count is zero (decoded from the count register).
module io_clamp_step_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          enable,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Settle counter: load on a step, otherwise count down to zero and stick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (enable && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/io_clamp_seq.sv
// IO-ring power clamp / isolation sequencer. Clamps or releases the IO supply
// segments one at a time (thermometer order from bit 0) with a settle wait
// after each enabled segment, and acknowledges on a level req/ack handshake.
// Reset lands in the safe state: every segment clamped and acknowledged.
//   clk      : always-on clock.
//   rst_n    : asynchronous active-low reset.
//   req_i    : 1 = clamp all segments, 0 = release all segments.
//   seg_en_i : per-segment settle enable, sampled at that segment's step.
//   clamp_o  : clamp enables, thermometer coded from bit 0.
//   ack_o    : follows req_i once a sequence has completed.
//   busy_o   : high while clamping or releasing is in progress.
//   state_o  : FSM state (OPEN=0, ASSERT=1, CLAMPED=2, RELEASE=3).
module io_clamp_seq
  import io_clamp_pkg::*;
#(
  parameter int N_SEG    = 4,
  parameter int STEP_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [N_SEG-1:0] seg_en_i,
  output logic [N_SEG-1:0] clamp_o,
  output logic             ack_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  localparam int CW   = $clog2(STEP_CYC);
  // A one-cycle step interval gives CW=0; keep at least one counter bit.
  localparam int CW_I = (CW < 1) ? 1 : CW;
  localparam int IW   = $clog2(N_SEG + 1);

  state_e           state_r;
  logic [IW-1:0]    idx_r;
  logic [N_SEG-1:0] clamp_r;
  logic             ack_r;
  logic             busy_r;

  logic             cnt_zero_s;
  logic             idx_full_s;
  logic             idx_empty_s;
  logic             step_up_s;
  logic             step_dn_s;
  logic             seg_up_s;
  logic             seg_dn_s;
  logic [CW_I-1:0]  load_val_s;
  logic [N_SEG-1:0] therm_up_s;
  logic [N_SEG-1:0] therm_dn_s;

  assign idx_full_s  = (idx_r == IW'(N_SEG));
  assign idx_empty_s = (idx_r == {IW{1'b0}});

  // A step happens only with the settle counter expired. The first step of a
  // sequence shares the edge that leaves OPEN/CLAMPED; a reversal edge never
  // steps because the direction no longer matches the state.
  assign step_up_s = cnt_zero_s && !idx_full_s && req_i &&
                     ((state_r == ST_OPEN) || (state_r == ST_ASSERT));
  assign step_dn_s = cnt_zero_s && !idx_empty_s && !req_i &&
                     ((state_r == ST_CLAMPED) || (state_r == ST_RELEASE));

  // Settle enable of the segment touched by the next step, and the clamp
  // pattern after an increment / decrement of idx.
  always_comb begin
    seg_up_s   = 1'b0;
    seg_dn_s   = 1'b0;
    therm_up_s = {N_SEG{1'b0}};
    therm_dn_s = {N_SEG{1'b0}};
    for (int i = 0; i < N_SEG; i++) begin
      seg_up_s      = seg_up_s | ((idx_r == IW'(i)) & seg_en_i[i]);
      seg_dn_s      = seg_dn_s | ((idx_r == IW'(i + 1)) & seg_en_i[i]);
      therm_up_s[i] = thermo_bit(5'(i), 5'(idx_r) + 5'd1);
      therm_dn_s[i] = thermo_bit(5'(i), 5'(idx_r) - 5'd1);
    end
  end

  assign load_val_s = (step_up_s ? seg_up_s : seg_dn_s) ? CW_I'(STEP_CYC - 1)
                                                        : {CW_I{1'b0}};

  io_clamp_step_timer #(
    .CW (CW_I)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (step_up_s | step_dn_s),
    .load_val (load_val_s),
    .enable   (busy_r),
    .zero     (cnt_zero_s)
  );

  // Sequencer FSM with segment count, clamp pattern and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLAMPED;
      idx_r   <= IW'(N_SEG);
      clamp_r <= {N_SEG{1'b1}};
      ack_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      if (step_up_s) begin
        idx_r   <= idx_r + IW'(1);
        clamp_r <= therm_up_s;
      end else if (step_dn_s) begin
        idx_r   <= idx_r - IW'(1);
        clamp_r <= therm_dn_s;
      end else begin
        idx_r   <= idx_r;
        clamp_r <= clamp_r;
      end

      state_r <= state_r;
      ack_r   <= ack_r;
      busy_r  <= busy_r;
      case (state_r)
        ST_OPEN: begin
          if (req_i) begin
            state_r <= ST_ASSERT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_OPEN;
          end
        end
        ST_ASSERT: begin
          if (!req_i) begin
            state_r <= ST_RELEASE;
          end else if (cnt_zero_s && idx_full_s) begin
            state_r <= ST_CLAMPED;
            ack_r   <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_ASSERT;
          end
        end
        ST_CLAMPED: begin
          if (!req_i) begin
            state_r <= ST_RELEASE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_CLAMPED;
          end
        end
        ST_RELEASE: begin
          if (req_i) begin
            state_r <= ST_ASSERT;
          end else if (cnt_zero_s && idx_empty_s) begin
            state_r <= ST_OPEN;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          state_r <= ST_CLAMPED;
          ack_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign clamp_o = clamp_r;
  assign ack_o   = ack_r;
  assign busy_o  = busy_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_io_clamp_seq.sv
// Directed testbench for io_clamp_seq: a 4-segment / 16-cycle instance and a
// 1-segment / 1-cycle instance. Edge 0 is the first clock edge that samples
// the new request; outputs are sampled 1 time unit after each edge.
module tb_io_clamp_seq;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [3:0] seg_en;
  logic [3:0] clamp;
  logic       ack;
  logic       busy;
  logic [1:0] state;

  logic       rst1_n;
  logic       req1;
  logic [0:0] seg_en1;
  logic [0:0] clamp1;
  logic       ack1;
  logic       busy1;
  logic [1:0] state1;

  int errors = 0;
  int checks = 0;

  io_clamp_seq #(.N_SEG(4), .STEP_CYC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .seg_en_i (seg_en),
    .clamp_o  (clamp),
    .ack_o    (ack),
    .busy_o   (busy),
    .state_o  (state)
  );

  io_clamp_seq #(.N_SEG(1), .STEP_CYC(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst1_n),
    .req_i    (req1),
    .seg_en_i (seg_en1),
    .clamp_o  (clamp1),
    .ack_o    (ack1),
    .busy_o   (busy1),
    .state_o  (state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0; rst1_n = 1'b0;
    req = 1'b1; req1 = 1'b1;
    seg_en = 4'b1111; seg_en1 = 1'b1;
    #12;
    exp = {4'b1111, 1'b1, 1'b0, 2'd2};
    checks++;
    if ({clamp, ack, busy, state} !== exp) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", {clamp, ack, busy, state}, exp);
    end
    checks++;
    if ({clamp1, ack1, busy1, state1} !== 5'b1_1_0_10) begin
      errors++;
      $display("FAIL reset_small got=%b exp=%b", {clamp1, ack1, busy1, state1}, 5'b1_1_0_10);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rst1_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({clamp, ack, busy, state} !== exp) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", {clamp, ack, busy, state}, exp);
    end
  endtask

  task automatic test_release();
    logic [3:0] ec;
    logic [7:0] exp;
    req = 1'b0;
    for (int e = 0; e <= 66; e++) begin
      @(posedge clk); #1;
      ec  = (e < 16) ? 4'b0111 : (e < 32) ? 4'b0011 : (e < 48) ? 4'b0001 : 4'b0000;
      exp = {ec, (e < 64), (e < 64), (e < 64) ? 2'd3 : 2'd0};
      checks++;
      if ({clamp, ack, busy, state} !== exp) begin
        errors++;
        $display("FAIL release edge=%0d got=%b exp=%b", e, {clamp, ack, busy, state}, exp);
      end
    end
  endtask

  task automatic test_assert();
    logic [3:0] ec;
    logic [7:0] exp;
    seg_en = 4'b1111;
    req = 1'b1;
    for (int e = 0; e <= 66; e++) begin
      @(posedge clk); #1;
      ec  = (e < 16) ? 4'b0001 : (e < 32) ? 4'b0011 : (e < 48) ? 4'b0111 : 4'b1111;
      exp = {ec, (e >= 64), (e < 64), (e < 64) ? 2'd1 : 2'd2};
      checks++;
      if ({clamp, ack, busy, state} !== exp) begin
        errors++;
        $display("FAIL assert edge=%0d got=%b exp=%b", e, {clamp, ack, busy, state}, exp);
      end
    end
  endtask

  // Release with every settle wait disabled: steps on edges 0..3, done on 4.
  task automatic go_open();
    seg_en = 4'b0000;
    req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({clamp, ack, busy, state} !== 8'b0000_0_0_00) begin
      errors++;
      $display("FAIL go_open got=%b exp=%b", {clamp, ack, busy, state}, 8'b0000_0_0_00);
    end
  endtask

  task automatic test_seg_en();
    logic [3:0] ec;
    logic [7:0] exp;
    go_open();
    seg_en = 4'b0101;
    req = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk); #1;
      ec  = (e < 16) ? 4'b0001 : (e < 17) ? 4'b0011 : (e < 33) ? 4'b0111 : 4'b1111;
      exp = {ec, (e >= 34), (e < 34), (e < 34) ? 2'd1 : 2'd2};
      checks++;
      if ({clamp, ack, busy, state} !== exp) begin
        errors++;
        $display("FAIL seg_en edge=%0d got=%b exp=%b", e, {clamp, ack, busy, state}, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] ec;
    logic [7:0] exp;
    go_open();
    seg_en = 4'b1111;
    req = 1'b1;
    for (int e = 0; e <= 70; e++) begin
      @(posedge clk); #1;
      if (e < 20) begin
        ec  = (e < 16) ? 4'b0001 : 4'b0011;
        exp = {ec, 1'b0, 1'b1, 2'd1};
      end else begin
        ec  = (e < 32) ? 4'b0011 : (e < 48) ? 4'b0001 : 4'b0000;
        exp = {ec, 1'b0, (e < 64), (e < 64) ? 2'd3 : 2'd0};
      end
      checks++;
      if ({clamp, ack, busy, state} !== exp) begin
        errors++;
        $display("FAIL abort edge=%0d got=%b exp=%b", e, {clamp, ack, busy, state}, exp);
      end
      if (e == 19) req = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    req = 1'b1;
    repeat (66) @(posedge clk);
    #1;
    checks++;
    if ({clamp, ack, state} !== 7'b1111_1_10) begin
      errors++;
      $display("FAIL pre_reset_clamped got=%b exp=%b", {clamp, ack, state}, 7'b1111_1_10);
    end
    req = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    checks++;
    if ({clamp, ack, busy, state} !== 8'b0011_1_1_11) begin
      errors++;
      $display("FAIL mid_release got=%b exp=%b", {clamp, ack, busy, state}, 8'b0011_1_1_11);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clamp, ack, busy, state} !== 8'b1111_1_0_10) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", {clamp, ack, busy, state}, 8'b1111_1_0_10);
    end
    req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    req1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({clamp1, ack1, busy1, state1} !== 5'b0_1_1_11) begin
      errors++;
      $display("FAIL small_rel_e0 got=%b exp=%b", {clamp1, ack1, busy1, state1}, 5'b0_1_1_11);
    end
    @(posedge clk); #1;
    checks++;
    if ({clamp1, ack1, busy1, state1} !== 5'b0_0_0_00) begin
      errors++;
      $display("FAIL small_rel_e1 got=%b exp=%b", {clamp1, ack1, busy1, state1}, 5'b0_0_0_00);
    end
    req1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({clamp1, ack1, busy1, state1} !== 5'b1_0_1_01) begin
      errors++;
      $display("FAIL small_asr_e0 got=%b exp=%b", {clamp1, ack1, busy1, state1}, 5'b1_0_1_01);
    end
    @(posedge clk); #1;
    checks++;
    if ({clamp1, ack1, busy1, state1} !== 5'b1_1_0_10) begin
      errors++;
      $display("FAIL small_asr_e1 got=%b exp=%b", {clamp1, ack1, busy1, state1}, 5'b1_1_0_10);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_assert();
    test_seg_en();
    test_abort();
    test_async_reset();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
